// File: rtl/alu_stream_pkg.sv
// alu_stream_pkg: shared defaults and index-width helper for the ALU result stream mux
package alu_stream_pkg;
    localparam int DEF_W = 32;
    localparam int DEF_N = 3;
    // Bits needed to index n channels; constant-foldable for parameter derivation.
    function automatic int idx_w(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/stream_mux_nto1_rr_grant.sv
// rr_grant: round-robin grant search over N requests starting at a pointer
// Ports: req (N request bits), ptr (search start, < N), gnt_idx (granted channel), gnt_vld (any request found).
// Only compiled when STREAM_MUX_RR_EN is defined.
`ifdef STREAM_MUX_RR_EN
module rr_grant #(
    parameter int N  = 3,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_vld
);
    localparam logic [SW:0] N_EXT = (SW+1)'(N);
    logic [SW:0] sum;
    // Walk offsets from farthest to nearest so the nearest valid channel from ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SW+1)'(k);
            sum = (sum >= N_EXT) ? sum - N_EXT : sum;
            if (req[sum[SW-1:0]]) begin
                gnt_idx = sum[SW-1:0];
                gnt_vld = 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: registered N-to-1 valid/ready stream mux with explicit select and optional round-robin
// Ports: in_data/in_valid/in_ready (N input channels), sel (explicit select, codes >= N grant nothing),
//        out_data/out_valid/out_ready (registered output stream), out_src (producing channel),
//        err_sel (previous cycle had a degenerate explicit select), rr_mode (round-robin, macro only).
// Define STREAM_MUX_RR_EN to add the rr_mode port and round-robin arbitration.
module stream_mux_nto1
    import alu_stream_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W,
    localparam int SW = idx_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef STREAM_MUX_RR_EN
    input  logic           rr_mode,
`endif
    output logic [SW-1:0]  out_src,
    output logic           err_sel
);
    localparam logic [SW:0] N_EXT = (SW+1)'(N);
    logic [W-1:0]  ch [N];
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_src_q, out_src_d;
    logic          out_valid_q, out_valid_d;
    logic          err_sel_q, err_sel_d;
    logic [SW-1:0] g;
    logic          gv, expl, sel_ok, load_en, xfer;

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign ch[i] = in_data[i*W +: W];
    end

    assign sel_ok  = {1'b0, sel} < N_EXT;
    assign load_en = !out_valid_q || out_ready;

`ifdef STREAM_MUX_RR_EN
    localparam logic [SW-1:0] LAST = SW'(N - 1);
    logic [SW-1:0] rr_ptr_q, rr_ptr_d, rr_g;
    logic          rr_gv;

    rr_grant #(.N(N), .SW(SW)) u_rr_grant (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (rr_g),
        .gnt_vld (rr_gv)
    );

    always_comb begin
        g        = rr_mode ? rr_g : sel;
        gv       = rr_mode ? rr_gv : sel_ok;
        expl     = !rr_mode;
        rr_ptr_d = !xfer ? rr_ptr_q : (g == LAST) ? '0 : g + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        g    = sel;
        gv   = sel_ok;
        expl = 1'b1;
    end
`endif

    // gv gates every use of g, so an out-of-range explicit select never reaches a channel.
    always_comb begin
        xfer        = gv && load_en && in_valid[g];
        in_ready    = (load_en && gv) ? ({{(N-1){1'b0}}, 1'b1} << g) : '0;
        out_data_d  = xfer ? ch[g] : out_data_q;
        out_src_d   = xfer ? g : out_src_q;
        out_valid_d = xfer || (out_valid_q && !out_ready);
        err_sel_d   = expl && !sel_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            err_sel_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            err_sel_q   <= err_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;
    assign err_sel   = err_sel_q;
endmodule
